// File: rtl/uart_tx_fmt.sv
// uart_tx_fmt: transmit back end of the serial debug unit.
// Accepts a send request (raw byte, 8-digit hex word, hex word + CR LF, or CR LF),
// formats it into ASCII characters and shifts each one out as 8N1 on txd.
// The request is acknowledged only once the final stop bit has left the line.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   req_tx   send request, held high by the requester until ack_tx
//   type_tx  0 raw byte dout[7:0], 1 hex word, 2 hex word + CR LF, 3 CR LF
//   dout     payload, captured when the request is accepted
//   ack_tx   one-cycle pulse after the last stop bit
//   txd      registered serial output, idle high
//   busy     high from acceptance through the ack_tx cycle
module uart_tx_fmt #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_tx,
  input  logic [1:0]  type_tx,
  input  logic [31:0] dout,
  output logic        ack_tx,
  output logic        txd,
  output logic        busy
);

  localparam int unsigned   CntW   = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);
  localparam logic [7:0]    ChCr   = 8'h0D;
  localparam logic [7:0]    ChLf   = 8'h0A;

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop, StAck} state_e;

  state_e          state_q, state_d;
  logic            armed_q, armed_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [2:0]      bit_q, bit_d;
  logic [31:0]     word_q, word_d;
  logic [1:0]      type_q, type_d;
  logic [7:0]      char_q, char_d;
  logic            txd_q, txd_d;
  logic            ack_q, ack_d;

  logic            bit_end;
  logic [3:0]      last_idx;
  logic [2:0]      nib_sel;
  logic [3:0]      nib;
  logic [7:0]      hex_char;
  logic [7:0]      char_sel;

  assign bit_end = (cnt_q == CntMax);

  // Index of the final character for the captured request type.
  always_comb begin
    last_idx = 4'd0;
    case (type_q)
      2'd0:    last_idx = 4'd0;
      2'd1:    last_idx = 4'd7;
      2'd2:    last_idx = 4'd9;
      default: last_idx = 4'd1;
    endcase
  end

  // Hex digits go out most significant nibble first.
  assign nib_sel = 3'd7 - idx_q[2:0];
  assign nib     = word_q[{nib_sel, 2'b00} +: 4];

  always_comb begin
    hex_char = 8'h30 + {4'h0, nib};
    if (nib >= 4'd10) begin
      hex_char = 8'h37 + {4'h0, nib};
    end
  end

  always_comb begin
    char_sel = hex_char;
    case (type_q)
      2'd0:    char_sel = word_q[7:0];
      2'd3:    char_sel = idx_q[0] ? ChLf : ChCr;
      default: begin
        if (idx_q == 4'd8) begin
          char_sel = ChCr;
        end else if (idx_q == 4'd9) begin
          char_sel = ChLf;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    word_d  = word_q;
    type_d  = type_q;
    char_d  = char_q;

    unique case (state_q)
      StIdle: begin
        if (!req_tx) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          word_d  = dout;
          type_d  = type_tx;
          idx_d   = 4'd0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        char_d  = char_sel;
        cnt_d   = '0;
        bit_d   = 3'd0;
        state_d = StStart;
      end
      StStart: begin
        cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        if (bit_end) begin
          if (idx_q == last_idx) begin
            state_d = StAck;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StLoad;
          end
        end
      end
      StAck: begin
        armed_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Line and ack are registered from the current state, so they trail the FSM by one
  // cycle: the start bit shows two edges after acceptance and ack lands right after
  // the last stop bit has finished on the line.
  always_comb begin
    txd_d = 1'b1;
    if (state_q == StStart) begin
      txd_d = 1'b0;
    end else if (state_q == StData) begin
      txd_d = char_q[bit_q];
    end
    ack_d = (state_q == StAck);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      armed_q <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      bit_q   <= 3'd0;
      word_q  <= 32'd0;
      type_q  <= 2'd0;
      char_q  <= 8'd0;
      txd_q   <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      type_q  <= type_d;
      char_q  <= char_d;
      txd_q   <= txd_d;
      ack_q   <= ack_d;
    end
  end

  assign txd    = txd_q;
  assign ack_tx = ack_q;
  // ack_q extends busy over the ack cycle after the FSM has already returned to idle.
  assign busy   = (state_q != StIdle) | ack_q;

endmodule
